// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam int DEF_MULT_LAT = 4;
    localparam int DEF_DIV_LAT  = 8;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide occupancy timer: holds EX for LAT cycles from issue.
//
//   state   | meaning
//   MD_IDLE | no MD op in EX; a start stalls this cycle and loads cnt = LAT-2
//   MD_BUSY | MD op still executing; stall while cnt != 0, release at cnt == 0
module md_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    input  logic abort,
    output logic busy,
    output logic releasing
);

    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW      = $clog2(MAX_LAT);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 2);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 2);

    md_state_t      state;
    logic [CW-1:0]  cnt;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        cnt   <= is_div ? DIV_LOAD : MULT_LOAD;
                        state <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    // start is ignored here: on the release edge ID/EX loads a fresh instruction
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= MD_IDLE;
                    end
                end
                default: begin
                    state <= MD_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy      = (state == MD_BUSY);
    assign releasing = (state == MD_BUSY) && (cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller: drives pipeline register enables/flushes and PC write.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT,
    parameter int CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_branch_taken,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_md_start,
    input  logic             ex_md_is_div,
    input  logic             exc_flush,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             exmem_flush,
    output logic             memwb_we,
    output logic             memwb_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    logic md_release;
    logic md_stall;
    logic load_use;

    md_busy_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_timer (
        .clk       (Clk),
        .rst       (Rst),
        .start     (ex_md_start),
        .is_div    (ex_md_is_div),
        .abort     (exc_flush),
        .busy      (md_busy),
        .releasing (md_release)
    );

    assign load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                      ((id_use_rs && (id_rs == ex_rd)) ||
                       (id_use_rt && (id_rt == ex_rd)));

    // Issue cycle stalls from IDLE; BUSY stalls every cycle except the release cycle.
    assign md_stall = md_busy ? !md_release : ex_md_start;

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_we     = 1'b1;
        idex_flush  = 1'b0;
        exmem_we    = 1'b1;
        exmem_flush = 1'b0;
        memwb_we    = 1'b1;
        memwb_flush = 1'b0;

        if (exc_flush) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (md_stall) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_flush = 1'b1;
        end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end else if (id_branch_taken) begin
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cycles <= '0;
        end else if (!pc_we && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl; a second 4-bit-counter instance checks saturation.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        Rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_use_rs, id_use_rt, id_branch_taken;
    logic        ex_mem_read, ex_md_start, ex_md_is_div, exc_flush;

    logic        pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
    logic        exmem_we, exmem_flush, memwb_we, memwb_flush, md_busy;
    logic [31:0] stall_cycles;

    logic        s_pc_we, s_ifid_we, s_ifid_flush, s_idex_we, s_idex_flush;
    logic        s_exmem_we, s_exmem_flush, s_memwb_we, s_memwb_flush, s_md_busy;
    logic [3:0]  s_stall_cycles;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m32;
    logic [3:0]  m4;

    // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush, memwb_we, memwb_flush, md_busy}
    localparam logic [9:0] V_NORM = 10'b1_1_0_1_0_1_0_1_0_0;
    localparam logic [9:0] V_LU   = 10'b0_0_0_1_1_1_0_1_0_0;
    localparam logic [9:0] V_BR   = 10'b1_1_1_1_0_1_0_1_0_0;
    localparam logic [9:0] V_MDI  = 10'b0_0_0_0_0_1_1_1_0_0;
    localparam logic [9:0] V_MDB  = 10'b0_0_0_0_0_1_1_1_0_1;
    localparam logic [9:0] V_REL  = 10'b1_1_0_1_0_1_0_1_0_1;
    localparam logic [9:0] V_EXCB = 10'b1_1_1_1_1_1_1_1_0_1;

    typedef struct {
        logic [9:0]  vec;
        logic [31:0] c32;
        logic [3:0]  c4;
        string       tag;
    } exp_t;

    exp_t sb[$];

    logic [9:0] obs;
    assign obs = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
                  exmem_we, exmem_flush, memwb_we, memwb_flush, md_busy};

    pipe_hazard_ctrl u_dut (
        .Clk             (clk),
        .Rst             (Rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_branch_taken (id_branch_taken),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_md_start     (ex_md_start),
        .ex_md_is_div    (ex_md_is_div),
        .exc_flush       (exc_flush),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .ifid_flush      (ifid_flush),
        .idex_we         (idex_we),
        .idex_flush      (idex_flush),
        .exmem_we        (exmem_we),
        .exmem_flush     (exmem_flush),
        .memwb_we        (memwb_we),
        .memwb_flush     (memwb_flush),
        .md_busy         (md_busy),
        .stall_cycles    (stall_cycles)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) u_sat (
        .Clk             (clk),
        .Rst             (Rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_branch_taken (id_branch_taken),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_md_start     (ex_md_start),
        .ex_md_is_div    (ex_md_is_div),
        .exc_flush       (exc_flush),
        .pc_we           (s_pc_we),
        .ifid_we         (s_ifid_we),
        .ifid_flush      (s_ifid_flush),
        .idex_we         (s_idex_we),
        .idex_flush      (s_idex_flush),
        .exmem_we        (s_exmem_we),
        .exmem_flush     (s_exmem_flush),
        .memwb_we        (s_memwb_we),
        .memwb_flush     (s_memwb_flush),
        .md_busy         (s_md_busy),
        .stall_cycles    (s_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic quiet();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_branch_taken = 1'b0;
        ex_mem_read = 1'b0; ex_md_start = 1'b0; ex_md_is_div = 1'b0; exc_flush = 1'b0;
    endtask

    task automatic load_use_rs(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_rd = rd; id_rs = 5'd5; id_use_rs = 1'b1;
    endtask

    // Inputs already driven (posedge+1); check mid-cycle, then advance the model over the edge.
    task automatic step(input logic [9:0] e, input string tag);
        exp_t x;
        x.vec = e; x.c32 = m32; x.c4 = m4; x.tag = tag;
        sb.push_back(x);
        #4;
        x = sb.pop_front();
        n_cmp++;
        assert (obs === x.vec) else begin
            n_fail++;
            $error("FAIL %s ctrl: got %b expected %b", x.tag, obs, x.vec);
        end
        n_cmp++;
        assert (stall_cycles === x.c32) else begin
            n_fail++;
            $error("FAIL %s stall_cycles: got %0d expected %0d", x.tag, stall_cycles, x.c32);
        end
        n_cmp++;
        assert (s_stall_cycles === x.c4) else begin
            n_fail++;
            $error("FAIL %s stall_cycles_w4: got %0d expected %0d", x.tag, s_stall_cycles, x.c4);
        end
        if (Rst) begin
            m32 = '0;
            m4  = '0;
        end else if (!e[9]) begin
            if (m32 != 32'hFFFF_FFFF) m32 = m32 + 1;
            if (m4 != 4'hF) m4 = m4 + 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        quiet();
        Rst = 1'b1;
        m32 = '0;
        m4  = '0;
        repeat (2) @(posedge clk);
        #1;
        Rst = 1'b0;

        step(V_NORM, "reset_quiet");

        load_use_rs(5'd5);
        step(V_LU, "lu_rs");
        quiet();
        step(V_NORM, "after_lu");

        load_use_rs(5'd0);
        id_rs = 5'd0;
        step(V_NORM, "lu_rd0");

        quiet();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_use_rt = 1'b1;
        step(V_LU, "lu_rt");
        id_use_rt = 1'b0;
        step(V_NORM, "rt_unused");
        ex_rd = 5'd8; id_use_rt = 1'b1;
        step(V_NORM, "rt_diff");

        quiet();
        id_branch_taken = 1'b1;
        step(V_BR, "branch");
        load_use_rs(5'd5);
        step(V_LU, "branch_lu");

        quiet();
        ex_md_start = 1'b1; ex_md_is_div = 1'b0;
        step(V_MDI, "mul_issue");
        id_branch_taken = 1'b1;
        load_use_rs(5'd5);
        step(V_MDB, "mul_busy_ign");
        quiet();
        ex_md_start = 1'b1;
        step(V_MDB, "mul_busy2");
        step(V_REL, "mul_release");
        ex_md_start = 1'b0;
        step(V_NORM, "mul_no_retrig");

        ex_md_start = 1'b1;
        step(V_MDI, "b2b_mul_issue");
        step(V_MDB, "b2b_mul_b1");
        step(V_MDB, "b2b_mul_b2");
        step(V_REL, "b2b_mul_rel");
        ex_md_is_div = 1'b1;
        step(V_MDI, "b2b_div_issue");
        for (int i = 0; i < 6; i++) step(V_MDB, "div_busy");
        step(V_REL, "div_release");
        quiet();
        step(V_NORM, "div_done");

        ex_md_start = 1'b1; ex_md_is_div = 1'b1;
        step(V_MDI, "exc_div_issue");
        for (int i = 0; i < 3; i++) step(V_MDB, "exc_div_busy");
        exc_flush = 1'b1;
        step(V_EXCB, "exc_cnt3");
        quiet();
        step(V_NORM, "exc_idle");

        n_cmp++;
        assert (s_stall_cycles === 4'hF) else begin
            n_fail++;
            $error("FAIL sat_hold: got %0d expected 15", s_stall_cycles);
        end

        ex_md_start = 1'b1; ex_md_is_div = 1'b1;
        step(V_MDI, "rst_div_issue");
        step(V_MDB, "rst_div_b1");
        step(V_MDB, "rst_div_b2");
        ex_md_start = 1'b0;
        Rst = 1'b1;
        step(V_MDB, "rst_cycle");
        Rst = 1'b0;
        step(V_NORM, "after_rst");

        load_use_rs(5'd5);
        step(V_LU, "lu_post_rst");
        quiet();
        step(V_NORM, "cnt_restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
